// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : E-stage multiply/divide sequencer owning HI/LO, with a fixed
//            busy window and a D-stage stall request. Divider built only
//            when MDU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_bits   = $clog2(c_max_cycles + 1);
    localparam int c_cnt_w      = (c_cnt_bits < 4) ? 4 : c_cnt_bits;

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] c_op_div   = 3'b010;
    localparam logic [2:0] c_op_divu  = 3'b011;
    localparam logic [c_cnt_w-1:0] c_div_cnt = c_cnt_w'(DIV_CYCLES);
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_res_hi;
    logic [31:0]          r_res_lo;
    logic                 r_res_ok;

    logic                 w_is_md;
    logic [c_cnt_w-1:0]   w_op_cnt;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;
    logic                 w_res_ok;
    logic                 w_load;
    logic                 w_commit;

    logic signed [63:0]   w_prod_s;
    logic [63:0]          w_prod_u;

    assign w_prod_s = $signed(a) * $signed(b);
    assign w_prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    logic                 w_b_nz;
    logic [31:0]          w_div_b;
    logic signed [31:0]   w_quot_s;
    logic signed [31:0]   w_rem_s;
    logic [31:0]          w_quot_u;
    logic [31:0]          w_rem_u;

    // A zero divisor is swapped for 1 so the divider never sees it; the
    // result is then suppressed at commit via w_res_ok.
    assign w_b_nz   = (b != 32'd0);
    assign w_div_b  = w_b_nz ? b : 32'd1;
    assign w_quot_s = $signed(a) / $signed(w_div_b);
    assign w_rem_s  = $signed(a) % $signed(w_div_b);
    assign w_quot_u = a / w_div_b;
    assign w_rem_u  = a % w_div_b;
`endif

    always_comb begin
        w_is_md  = 1'b0;
        w_op_cnt = c_mult_cnt;
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_ok = 1'b1;
        case (mdop)
            c_op_mult: begin
                w_is_md              = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_s;
            end
            c_op_multu: begin
                w_is_md              = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_u;
            end
`ifdef MDU_DIV_EN
            c_op_div: begin
                w_is_md  = 1'b1;
                w_op_cnt = c_div_cnt;
                w_res_hi = w_rem_s;
                w_res_lo = w_quot_s;
                w_res_ok = w_b_nz;
            end
            c_op_divu: begin
                w_is_md  = 1'b1;
                w_op_cnt = c_div_cnt;
                w_res_hi = w_rem_u;
                w_res_lo = w_quot_u;
                w_res_ok = w_b_nz;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_md) begin
                    w_state_next = S_BUSY;
                    w_cnt_next   = w_op_cnt;
                    w_load       = 1'b1;
                end
            end
            S_BUSY: begin
                w_cnt_next = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_next = S_IDLE;
                    w_commit     = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_ok <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_load) begin
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_res_ok <= w_res_ok;
            end
            if (w_commit) begin
                if (r_res_ok) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
            end else if (r_state == S_IDLE && start) begin
                // Moves to HI/LO only take effect when no operation is in flight.
                if (mdop == c_op_mthi) r_hi <= a;
                if (mdop == c_op_mtlo) r_lo <= a;
            end
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = (r_cnt != '0);
    assign stall_req = md_use_d && (busy || (start && w_is_md));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Directed self-checking bench for mdu_ctrl (both MDU_DIV_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdop      (mdop),
        .a         (a),
        .b         (b),
        .md_use_d  (md_use_d),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    // Present an operation for the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        a     = va;
        b     = vb;
    endtask

    // Advance past the sampling edge and drop start.
    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        mdop  = 3'b111;
        a     = 32'd0;
        b     = 32'd0;
    endtask

    // Count cycles with busy high, bounded so a stuck busy still terminates.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b1;
        mdop     = 3'b000;
        md_use_d = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_stall_comb: got %b want 1", stall_req);
        end
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall_idle: got %b want 0", stall_req);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall_req !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: hi=%h lo=%h busy=%b stall=%b want 0/0/0/0",
                         i, hi, lo, busy, stall_req);
            end
        end
        md_use_d = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        issue(3'b000, 32'hFFFF_FFFF, 32'd2);
        release_start();
        checks++;
        if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL mult_early: busy=%b hi=%h lo=%h want 1/0/0", busy, hi, lo);
        end
        count_busy(n);
        checks++;
        if (n != MC) begin
            failures++;
            $display("FAIL mult_busy_len: got %0d want %0d", n, MC);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL mult_result: hi=%h lo=%h want ffffffff/fffffffe", hi, lo);
        end

        issue(3'b001, 32'hFFFF_FFFF, 32'd2);
        release_start();
        count_busy(n);
        checks++;
        if (n != MC || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_result: n=%0d hi=%h lo=%h want %0d/00000001/fffffffe", n, hi, lo, MC);
        end

        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        release_start();
        count_busy(n);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            failures++;
            $display("FAIL mult_neg: hi=%h lo=%h want ffffffff/ffffffeb", hi, lo);
        end

        issue(3'b001, 32'h1234_5678, 32'h0000_0010);
        release_start();
        count_busy(n);
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'h2345_6780) begin
            failures++;
            $display("FAIL multu_big: hi=%h lo=%h want 00000001/23456780", hi, lo);
        end
    endtask

    task automatic test_stall();
        int bad;
        md_use_d = 1'b1;
        issue(3'b000, 32'd1, 32'd1);
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_start_cycle: got %b want 1", stall_req);
        end
        release_start();
        bad = 0;
        for (int k = 0; k < MC; k++) begin
            if (stall_req !== 1'b1 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_window: %0d cycles without stall/busy, want 0", bad);
        end
        checks++;
        if (stall_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_drop: stall=%b busy=%b want 0/0", stall_req, busy);
        end

        md_use_d = 1'b0;
        issue(3'b000, 32'd1, 32'd1);
        bad = 0;
        #1;
        if (stall_req !== 1'b0) bad++;
        release_start();
        for (int k = 0; k < MC + 1; k++) begin
            if (stall_req !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_no_use: %0d cycles with stall, want 0", bad);
        end
    endtask

    task automatic test_mthi_mtlo();
        md_use_d = 1'b1;
        issue(3'b100, 32'h1234_5678, 32'd0);
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL mthi_stall: got %b want 0", stall_req);
        end
        release_start();
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b want 12345678/00000001/0", hi, lo, busy);
        end
        issue(3'b101, 32'hCAFE_BABE, 32'd0);
        release_start();
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b want 12345678/cafebabe/0", hi, lo, busy);
        end
        md_use_d = 1'b0;
    endtask

    task automatic test_div();
        int n;
`ifdef MDU_DIV_EN
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        release_start();
        count_busy(n);
        checks++;
        if (n != DC || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_neg: n=%0d hi=%h lo=%h want %0d/ffffffff/fffffffd", n, hi, lo, DC);
        end
        issue(3'b011, 32'd7, 32'd0);
        release_start();
        count_busy(n);
        checks++;
        if (n != DC || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL divu_zero: n=%0d hi=%h lo=%h want %0d/ffffffff/fffffffd", n, hi, lo, DC);
        end
        issue(3'b011, 32'd100, 32'd7);
        release_start();
        count_busy(n);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL divu: hi=%h lo=%h want 00000002/0000000e", hi, lo);
        end
        issue(3'b010, 32'd7, 32'hFFFF_FFFE);
        release_start();
        count_busy(n);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
            failures++;
            $display("FAIL div_negdiv: hi=%h lo=%h want 00000001/fffffffd", hi, lo);
        end
`else
        md_use_d = 1'b1;
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL div_noop_stall: got %b want 0", stall_req);
        end
        release_start();
        count_busy(n);
        checks++;
        if (n != 0 || hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL div_noop: n=%0d hi=%h lo=%h want 0/12345678/cafebabe", n, hi, lo);
        end
        issue(3'b011, 32'd7, 32'd0);
        release_start();
        count_busy(n);
        checks++;
        if (n != 0 || hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL divu_noop: n=%0d hi=%h lo=%h want 0/12345678/cafebabe", n, hi, lo);
        end
        md_use_d = 1'b0;
`endif
    endtask

    task automatic test_start_while_busy();
        int n;
        issue(3'b000, 32'd3, 32'd5);
        release_start();
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'b001;
        a     = 32'd100;
        b     = 32'd100;
        release_start();
        count_busy(n);
        checks++;
        if (n != MC - 2) begin
            failures++;
            $display("FAIL busy_ignore_len: got %0d want %0d", n, MC - 2);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd15) begin
            failures++;
            $display("FAIL busy_ignore_result: hi=%h lo=%h want 00000000/0000000f", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lo !== 32'd15) begin
            failures++;
            $display("FAIL busy_ignore_after: busy=%b lo=%h want 0/0000000f", busy, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'b000, 32'd2, 32'd3);
        release_start();
        count_busy(n);
        // First idle cycle: launch the next operation immediately.
        start = 1'b1;
        mdop  = 3'b000;
        a     = 32'd4;
        b     = 32'd5;
        checks++;
        if (n != MC || lo !== 32'd6 || hi !== 32'd0) begin
            failures++;
            $display("FAIL b2b_first: n=%0d hi=%h lo=%h want %0d/0/6", n, hi, lo, MC);
        end
        release_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b want 1", busy);
        end
        count_busy(n);
        checks++;
        if (n != MC || lo !== 32'd20 || hi !== 32'd0) begin
            failures++;
            $display("FAIL b2b_second: n=%0d hi=%h lo=%h want %0d/0/20", n, hi, lo, MC);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
`ifdef MDU_DIV_EN
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
`else
        issue(3'b000, 32'hFFFF_FFF9, 32'd2);
`endif
        release_start();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < DC + 2; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mid_late: %0d cycles nonzero after abort, want 0", bad);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mdop     = 3'b111;
        a        = 32'd0;
        b        = 32'd0;
        md_use_d = 1'b0;
        test_reset();
        test_mult();
        test_stall();
        test_mthi_mtlo();
        test_div();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
